rca8_mp_seq: RTL and testbench



---
 rtl/rca8_mp_seq.sv | 110 +++++++++++
 tb/tb_rca8_mp_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca8_mp_seq.sv
// rtl/rca8_mp_seq.sv - multi-precision add sequencer driving one shared 8-bit ripple-carry adder
module rca8_mp_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [8*NBYTES-1:0] a_reg;
  logic [8*NBYTES-1:0] b_reg;
  logic                carry;
  logic [IW-1:0]       idx;

  // State register; reset returns to IDLE regardless of start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and status/adder-operand outputs, all derived from registers only.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    add_a    = 8'h00;
    add_b    = 8'h00;
    add_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[idx*8 +: 8];
        add_b   = b_reg[idx*8 +: 8];
        add_cin = carry;
        if (idx == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fold one adder byte per RUN cycle into result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= op_a;
            b_reg  <= op_b;
            carry  <= cin;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
          end
        end
        RUN: begin
          result[idx*8 +: 8] <= add_sum;
          carry              <= add_cout;
          if (idx == LAST) begin
            cout <= add_cout;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca8_mp_seq.sv
// tb/tb_rca8_mp_seq.sv - directed self-checking bench for rca8_mp_seq with NBYTES=4
module tb_rca8_mp_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;

  int tests_run = 0;
  int tests_failed = 0;

  rca8_mp_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Stand-in for the combinational rca_8 that sits next to the sequencer.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // One clock: inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a start for one cycle (cycle 0) and advance into cycle 1.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic c);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h01234567; cin = 1'b1;
    step(); step();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_status: got busy=%b done=%b, required 0 0", busy, done);
    end
    tests_run++;
    if (result !== 32'h0 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_result: got %h/%b, required 00000000/0", result, cout);
    end
    tests_run++;
    if (add_a !== 8'h00 || add_b !== 8'h00 || add_cin !== 1'b0) begin
      tests_failed++; $display("FAIL reset_adder: got %h %h %b, required 00 00 0", add_a, add_b, add_cin);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int bad = 0;
    launch(32'h000000FF, 32'h00000001, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      step();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL basic_busy: got %0d bad cycles in 1..4, required 0", bad);
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done: got done=%b busy=%b in cycle 5, required 1 0", done, busy);
    end
    tests_run++;
    if (result !== 32'h00000100 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL basic_result: got %h/%b, required 00000100/0", result, cout);
    end
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done_pulse: got done=%b in cycle 6, required 0", done);
    end
  endtask

  task automatic test_ripple();
    launch(32'hFFFFFFFF, 32'h00000000, 1'b1);
    step(); step(); step(); step();
    tests_run++;
    if (done !== 1'b1 || result !== 32'h00000000 || cout !== 1'b1) begin
      tests_failed++; $display("FAIL ripple: got done=%b %h/%b, required 1 00000000/1", done, result, cout);
    end
    step();
  endtask

  task automatic test_mixed();
    logic [7:0] exp_a [4];
    logic [7:0] got_a [4];
    exp_a[0] = 8'h78; exp_a[1] = 8'h56; exp_a[2] = 8'h34; exp_a[3] = 8'h12;
    launch(32'h12345678, 32'h9ABCDEF0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      got_a[c] = add_a;
      step();
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (got_a[c] !== exp_a[c]) begin
        tests_failed++; $display("FAIL mixed_add_a%0d: got %h, required %h", c + 1, got_a[c], exp_a[c]);
      end
    end
    tests_run++;
    if (done !== 1'b1 || result !== 32'hACF13568 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL mixed_result: got done=%b %h/%b, required 1 ACF13568/0", done, result, cout);
    end
    step();
  endtask

  task automatic test_overflow_hold();
    int bad = 0;
    launch(32'h80000000, 32'h80000000, 1'b0);
    step(); step(); step(); step();
    tests_run++;
    if (done !== 1'b1 || result !== 32'h00000000 || cout !== 1'b1) begin
      tests_failed++; $display("FAIL overflow: got done=%b %h/%b, required 1 00000000/1", done, result, cout);
    end
    op_a = 32'h5555AAAA; op_b = 32'h12345678; cin = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || cout !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL overflow_hold: got %0d bad idle cycles, required 0", bad);
    end
  endtask

  task automatic test_ignore_start();
    launch(32'h11111111, 32'h22222222, 1'b0);          // now cycle 1
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001;
    step();                                            // cycle 2
    start = 1'b1;
    step();                                            // cycle 3
    start = 1'b0;
    step(); step();                                    // cycle 5
    start = 1'b1;
    tests_run++;
    if (done !== 1'b1 || result !== 32'h33333333 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL ignore_result: got done=%b %h/%b, required 1 33333333/0", done, result, cout);
    end
    step();                                            // cycle 6
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL ignore_done_start: got busy=%b done=%b in cycle 6, required 0 0", busy, done);
    end
    step();                                            // cycle 7
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL ignore_accept: got busy=%b in cycle 7, required 1", busy);
    end
    step(); step(); step(); step();                    // cycle 11
    tests_run++;
    if (done !== 1'b1 || result !== 32'h00000000 || cout !== 1'b1) begin
      tests_failed++; $display("FAIL ignore_second: got done=%b %h/%b, required 1 00000000/1", done, result, cout);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    launch(32'h12345678, 32'h9ABCDEF0, 1'b0);          // cycle 1
    step(); step();                                    // cycle 3
    rst = 1'b1;
    step();                                            // cycle 4
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || cout !== 1'b0 || add_a !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b done=%b %h/%b add_a=%h, required 0 0 00000000/0 00",
               busy, done, result, cout, add_a);
    end
    for (int c = 0; c < 6; c++) begin
      if (done !== 1'b0) pulses++;
      step();
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++; $display("FAIL reset_mid_no_done: got %0d done cycles, required 0", pulses);
    end
    launch(32'h000000FF, 32'h00000001, 1'b0);
    step(); step(); step(); step();
    tests_run++;
    if (done !== 1'b1 || result !== 32'h00000100 || cout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_recover: got done=%b %h/%b, required 1 00000100/0", done, result, cout);
    end
    step();
  endtask

  task automatic test_reset_start();
    rst = 1'b1;
    launch(32'h0000FFFF, 32'h00000001, 1'b0);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || result !== 32'h0) begin
      tests_failed++; $display("FAIL reset_start: got busy=%b result=%h, required 0 00000000", busy, result);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_mixed();
    test_overflow_hold();
    test_ignore_start();
    test_reset_mid();
    test_reset_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
